uart_cmd_framer: RTL and testbench

- Upstream stage for the UART transmitter in the car control path.
- Accepts motor/control commands (command ID plus two payload bytes) on a valid/ready interface and buffers them in a small FIFO.
- Serialises each command into a fixed byte frame: header, command, payload0, payload1, checksum.
- Presents the frame one byte at a time on a byte-wide valid/ready interface that connects directly to the transmitter's data_tx/valid/ready.

---
 rtl/uart_cmd_framer.sv | 143 ++++++++++++++
 tb/tb_uart_cmd_framer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: buffers {id,p0,p1} commands in a FIFO and streams each
// as HEADER,CMD,P0,P1,CHK bytes over a valid/ready byte interface.
// Ports: clk, rst (async, active-high); cmd_id/cmd_p0/cmd_p1/cmd_valid/
// cmd_ready command input; tx_data/tx_valid/tx_ready byte output;
// busy, frame_done, fifo_count status.
// Option: define UART_FRAMER_SEQ_EN to add a sequence byte after HEADER.
module uart_cmd_framer #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  HEADER_BYTE = 8'hAA,
  parameter int          BITS_N      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BITS_N-1:0]           cmd_id,
  input  logic [BITS_N-1:0]           cmd_p0,
  input  logic [BITS_N-1:0]           cmd_p1,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic [BITS_N-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 * BITS_N;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_CMD    = 3'd3;
  localparam logic [2:0] S_PAY0   = 3'd4;
  localparam logic [2:0] S_PAY1   = 3'd5;
  localparam logic [2:0] S_CHKSUM = 3'd6;
`ifdef UART_FRAMER_SEQ_EN
  localparam logic [2:0] S_SEQ    = 3'd2;
  localparam logic [2:0] S_AFTER_HDR = S_SEQ;
`else
  localparam logic [2:0] S_AFTER_HDR = S_CMD;
`endif

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [EW-1:0]     frame_q;
  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              push;
  logic              pop;
  logic [BITS_N-1:0] f_id;
  logic [BITS_N-1:0] f_p0;
  logic [BITS_N-1:0] f_p1;
  logic [BITS_N-1:0] chksum;

  assign {f_id, f_p0, f_p1} = frame_q;

  assign cmd_ready  = (count != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_IDLE) && (count != '0);
  assign fifo_count = count;

  // tx_valid depends on state only, so it falls with the async reset
  assign tx_valid   = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_CHKSUM) && tx_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_id, cmd_p0, cmd_p1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      state_q <= S_IDLE;
    end else begin
      if (pop) frame_q <= mem[rd_ptr];
      state_q <= state_d;
    end
  end

`ifdef UART_FRAMER_SEQ_EN
  logic [BITS_N-1:0] seq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             seq_q <= '0;
    else if (frame_done) seq_q <= seq_q + BITS_N'(1);
  end

  assign chksum = f_id + f_p0 + f_p1 + seq_q;
`else
  assign chksum = f_id + f_p0 + f_p1;
`endif

  // tx_valid is high in every non-IDLE state, so tx_ready alone
  // completes the handshake there
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (pop)      state_d = S_HEADER;
      S_HEADER: if (tx_ready) state_d = S_AFTER_HDR;
`ifdef UART_FRAMER_SEQ_EN
      S_SEQ:    if (tx_ready) state_d = S_CMD;
`endif
      S_CMD:    if (tx_ready) state_d = S_PAY0;
      S_PAY0:   if (tx_ready) state_d = S_PAY1;
      S_PAY1:   if (tx_ready) state_d = S_CHKSUM;
      S_CHKSUM: if (tx_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data = '0;
    unique case (state_q)
      S_HEADER: tx_data = HEADER_BYTE;
`ifdef UART_FRAMER_SEQ_EN
      S_SEQ:    tx_data = seq_q;
`endif
      S_CMD:    tx_data = f_id;
      S_PAY0:   tx_data = f_p0;
      S_PAY1:   tx_data = f_p1;
      S_CHKSUM: tx_data = chksum;
      default:  tx_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed self-checking bench for uart_cmd_framer.
// Table of commands with hand-computed checksums plus corner sequences.
module tb_uart_cmd_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_id, cmd_p0, cmd_p1;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  uart_cmd_framer dut (
    .clk(clk), .rst(rst),
    .cmd_id(cmd_id), .cmd_p0(cmd_p0), .cmd_p1(cmd_p1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .fifo_count(fifo_count)
  );

  always #10 clk = ~clk;

`ifdef UART_FRAMER_SEQ_EN
  localparam int SEQN = 1;
`else
  localparam int SEQN = 0;
`endif
  localparam int NB = 5 + SEQN;

  typedef struct {
    logic [7:0] id;
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] chk;
  } vec_t;

  vec_t       vt[6];
  int         tests = 0;
  int         fails = 0;
  int         fd_cnt = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_seq = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] id, input logic [7:0] p0,
                      input logic [7:0] p1, input logic exp_rdy);
    cmd_id = id; cmd_p0 = p0; cmd_p1 = p1; cmd_valid = 1'b1;
    chk("cmd_ready", cmd_ready, exp_rdy);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int cyc = 0;
    while (rx.size() < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rx_count", rx.size(), n);
  endtask

  task automatic wait_valid();
    int cyc = 0;
    while (!tx_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("tx_valid_seen", tx_valid, 1);
  endtask

  task automatic pulse_ready(input int n);
    for (int i = 0; i < n; i++) begin
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
  endtask

  task automatic check_frame(input int base, input vec_t v);
    logic [7:0] e[$];
    e.push_back(8'hAA);
    if (SEQN != 0) e.push_back(exp_seq);
    e.push_back(v.id);
    e.push_back(v.p0);
    e.push_back(v.p1);
    e.push_back(v.chk + ((SEQN != 0) ? exp_seq : 8'h00));
    for (int i = 0; i < NB; i++) begin
      if (base + i < rx.size()) chk("frame_byte", rx[base+i], e[i]);
      else chk("frame_missing", 0, 1);
    end
    exp_seq = exp_seq + 8'h01;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_seq = 8'h00;
    rx.delete();
  endtask

  task automatic send_frame(input vec_t v);
    int fd0;
    tx_ready = 1'b1;
    rx.delete();
    fd0 = fd_cnt;
    push(v.id, v.p0, v.p1, 1'b1);
    wait_rx(NB, 100);
    check_frame(0, v);
    chk("frame_done_cnt", fd_cnt - fd0, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    vec_t v;
    vt[0] = '{8'h01, 8'h40, 8'h80, 8'hC1};
    vt[1] = '{8'hFF, 8'h02, 8'h00, 8'h01};
    vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vt[3] = '{8'h80, 8'h80, 8'h80, 8'h80};
    vt[4] = '{8'h12, 8'h34, 8'h56, 8'h9C};
    vt[5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFD};

    rst = 1'b1; cmd_valid = 1'b0; tx_ready = 1'b0;
    cmd_id = '0; cmd_p0 = '0; cmd_p1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) send_frame(vt[i]);

    // backpressure in PAY0
    tx_ready = 1'b0;
    rx.delete();
    push(8'h01, 8'h40, 8'h80, 1'b1);
    wait_valid();
    pulse_ready(2 + SEQN);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'h40)) bad++;
    end
    @(posedge clk); #1;
    chk("bp_hold_bad_cycles", bad, 0);
    tx_ready = 1'b1;
    wait_rx(NB, 100);
    check_frame(0, vt[0]);

    // FIFO full with transmitter stalled
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(vt[i].id, vt[i].p0, vt[i].p1, 1'b1);
    push(8'h77, 8'h77, 8'h77, 1'b0);
    chk("full_fifo_count", fifo_count, 4);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    tx_ready = 1'b1;
    wait_rx(5 * NB, 400);
    for (int i = 0; i < 5; i++) check_frame(i * NB, vt[i]);
    repeat (10) @(posedge clk);
    #1;
    chk("full_no_extra", rx.size(), 5 * NB);

    // reset mid-frame
    do_reset();
    tx_ready = 1'b0;
    push(vt[0].id, vt[0].p0, vt[0].p1, 1'b1);
    push(vt[1].id, vt[1].p0, vt[1].p1, 1'b1);
    push(vt[2].id, vt[2].p0, vt[2].p1, 1'b1);
    wait_valid();
    pulse_ready(2 + SEQN);
    chk("mid_pay0_data", tx_data, 8'h40);
    chk("mid_fifo_before", fifo_count, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_fifo_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_seq = 8'h00;
    send_frame(vt[4]);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_stale", rx.size(), NB);

`ifdef UART_FRAMER_SEQ_EN
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(vt[0]);
    v = vt[0];
    for (int i = 3; i < 255; i++) send_frame(v);
    chk("seq_model_ff", exp_seq, 8'hFF);
    send_frame(v);
    send_frame(v);
`else
    v = vt[0];
    chk("noseq_idle_data", tx_data, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
